// File: rtl/mem_arbiter.sv
// Arbitrates one single-port unified memory between the instruction-fetch and data ports.
// Each access runs IDLE -> ACCESS (WAIT_CYCLES+1 cycles) -> DONE (one-cycle ACK).
`timescale 1ns/1ps

module mem_arbiter #(
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned DATA_PRIO   = 1
) (
    input  logic          CLK,
    input  logic          Z_R,
    input  logic          IM_REQ,
    input  logic [AW-1:0] IM_ADDR,
    output logic          IM_ACK,
    output logic [DW-1:0] IM_DATA,
    input  logic          DM_REQ,
    input  logic          DM_WE,
    input  logic [AW-1:0] DM_ADDR,
    input  logic [DW-1:0] DM_WR_DATA,
    output logic          DM_ACK,
    output logic [DW-1:0] DM_RD_DATA,
    output logic          MEM_EN,
    output logic          MEM_WE,
    output logic [AW-3:0] MEM_ADDR,
    output logic [DW-1:0] MEM_WR_DATA,
    input  logic [DW-1:0] MEM_RD_DATA,
    output logic          BUSY
);

    localparam int unsigned CW  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int unsigned MAW = AW - 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            gnt_dm, gnt_dm_nxt;
    logic            last_dm, last_dm_nxt;
    logic            we_lat, we_lat_nxt;
    logic            pick_dm;
    logic [MAW-1:0]  addr_q, addr_nxt;
    logic [DW-1:0]   wdata_q, wdata_nxt;
    logic            en_q, en_nxt;
    logic            mwe_q, mwe_nxt;
    logic            im_ack_q, im_ack_nxt;
    logic            dm_ack_q, dm_ack_nxt;
    logic            busy_q, busy_nxt;
    logic [DW-1:0]   im_data_q, im_data_nxt;
    logic [DW-1:0]   dm_data_q, dm_data_nxt;

    // Byte-offset bits are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{IM_ADDR[1:0], DM_ADDR[1:0]};

    // Next-state and next-output logic; every output is registered from these.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        gnt_dm_nxt  = gnt_dm;
        last_dm_nxt = last_dm;
        we_lat_nxt  = we_lat;
        pick_dm     = 1'b0;
        addr_nxt    = addr_q;
        wdata_nxt   = wdata_q;
        en_nxt      = 1'b0;
        mwe_nxt     = 1'b0;
        im_ack_nxt  = 1'b0;
        dm_ack_nxt  = 1'b0;
        im_data_nxt = im_data_q;
        dm_data_nxt = dm_data_q;

        case (state)
            IDLE: begin
                if (IM_REQ || DM_REQ) begin
                    if (IM_REQ && DM_REQ) begin
                        pick_dm = (DATA_PRIO != 0) ? 1'b1 : !last_dm;
                    end else begin
                        pick_dm = DM_REQ;
                    end
                    gnt_dm_nxt  = pick_dm;
                    last_dm_nxt = pick_dm;
                    we_lat_nxt  = pick_dm && DM_WE;
                    addr_nxt    = pick_dm ? DM_ADDR[AW-1:2] : IM_ADDR[AW-1:2];
                    wdata_nxt   = pick_dm ? DM_WR_DATA : '0;
                    cnt_nxt     = CW'(WAIT_CYCLES);
                    state_nxt   = ACCESS;
                    en_nxt      = 1'b1;
                    mwe_nxt     = we_lat_nxt && (WAIT_CYCLES == 0);
                end
            end
            ACCESS: begin
                if (cnt == '0) begin
                    state_nxt  = DONE;
                    im_ack_nxt = !gnt_dm;
                    dm_ack_nxt = gnt_dm;
                    if (!we_lat) begin
                        if (gnt_dm) begin
                            dm_data_nxt = MEM_RD_DATA;
                        end else begin
                            im_data_nxt = MEM_RD_DATA;
                        end
                    end
                end else begin
                    cnt_nxt = cnt - CW'(1);
                    en_nxt  = 1'b1;
                    // Write strobe only in the final access cycle.
                    mwe_nxt = we_lat && (cnt_nxt == '0);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge CLK or negedge Z_R) begin
        if (!Z_R) begin
            state     <= IDLE;
            cnt       <= '0;
            gnt_dm    <= 1'b0;
            last_dm   <= 1'b1;
            we_lat    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            en_q      <= 1'b0;
            mwe_q     <= 1'b0;
            im_ack_q  <= 1'b0;
            dm_ack_q  <= 1'b0;
            busy_q    <= 1'b0;
            im_data_q <= '0;
            dm_data_q <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            gnt_dm    <= gnt_dm_nxt;
            last_dm   <= last_dm_nxt;
            we_lat    <= we_lat_nxt;
            addr_q    <= addr_nxt;
            wdata_q   <= wdata_nxt;
            en_q      <= en_nxt;
            mwe_q     <= mwe_nxt;
            im_ack_q  <= im_ack_nxt;
            dm_ack_q  <= dm_ack_nxt;
            busy_q    <= busy_nxt;
            im_data_q <= im_data_nxt;
            dm_data_q <= dm_data_nxt;
        end
    end

    assign IM_ACK      = im_ack_q;
    assign IM_DATA     = im_data_q;
    assign DM_ACK      = dm_ack_q;
    assign DM_RD_DATA  = dm_data_q;
    assign MEM_EN      = en_q;
    assign MEM_WE      = mwe_q;
    assign MEM_ADDR    = addr_q;
    assign MEM_WR_DATA = wdata_q;
    assign BUSY        = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances (W=1 fixed prio, W=1 round-robin, W=0)
// share one stimulus set and a small read-only memory image.
`timescale 1ns/1ps

module tb_mem_arbiter;

    localparam int IM = 1;
    localparam int DM = 2;

    logic        clk;
    logic        z_r;
    logic        im_req;
    logic [31:0] im_addr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wr_data;

    logic [31:0] rom [16];

    logic        a_im_ack, a_dm_ack, a_en, a_we, a_busy;
    logic [31:0] a_im_data, a_dm_rd, a_wd, a_rd;
    logic [29:0] a_addr;
    logic        b_im_ack, b_dm_ack, b_en, b_we, b_busy;
    logic [31:0] b_im_data, b_dm_rd, b_wd, b_rd;
    logic [29:0] b_addr;
    logic        c_im_ack, c_dm_ack, c_en, c_we, c_busy;
    logic [31:0] c_im_data, c_dm_rd, c_wd, c_rd;
    logic [29:0] c_addr;

    int n_cmp;
    int n_err;

    assign a_rd = rom[a_addr[3:0]];
    assign b_rd = rom[b_addr[3:0]];
    assign c_rd = rom[c_addr[3:0]];

    mem_arbiter #(.AW(32), .DW(32), .WAIT_CYCLES(1), .DATA_PRIO(1)) u_a (
        .CLK(clk), .Z_R(z_r),
        .IM_REQ(im_req), .IM_ADDR(im_addr), .IM_ACK(a_im_ack), .IM_DATA(a_im_data),
        .DM_REQ(dm_req), .DM_WE(dm_we), .DM_ADDR(dm_addr), .DM_WR_DATA(dm_wr_data),
        .DM_ACK(a_dm_ack), .DM_RD_DATA(a_dm_rd),
        .MEM_EN(a_en), .MEM_WE(a_we), .MEM_ADDR(a_addr), .MEM_WR_DATA(a_wd),
        .MEM_RD_DATA(a_rd), .BUSY(a_busy)
    );

    mem_arbiter #(.AW(32), .DW(32), .WAIT_CYCLES(1), .DATA_PRIO(0)) u_b (
        .CLK(clk), .Z_R(z_r),
        .IM_REQ(im_req), .IM_ADDR(im_addr), .IM_ACK(b_im_ack), .IM_DATA(b_im_data),
        .DM_REQ(dm_req), .DM_WE(dm_we), .DM_ADDR(dm_addr), .DM_WR_DATA(dm_wr_data),
        .DM_ACK(b_dm_ack), .DM_RD_DATA(b_dm_rd),
        .MEM_EN(b_en), .MEM_WE(b_we), .MEM_ADDR(b_addr), .MEM_WR_DATA(b_wd),
        .MEM_RD_DATA(b_rd), .BUSY(b_busy)
    );

    mem_arbiter #(.AW(32), .DW(32), .WAIT_CYCLES(0), .DATA_PRIO(1)) u_c (
        .CLK(clk), .Z_R(z_r),
        .IM_REQ(im_req), .IM_ADDR(im_addr), .IM_ACK(c_im_ack), .IM_DATA(c_im_data),
        .DM_REQ(dm_req), .DM_WE(dm_we), .DM_ADDR(dm_addr), .DM_WR_DATA(dm_wr_data),
        .DM_ACK(c_dm_ack), .DM_RD_DATA(c_dm_rd),
        .MEM_EN(c_en), .MEM_WE(c_we), .MEM_ADDR(c_addr), .MEM_WR_DATA(c_wd),
        .MEM_RD_DATA(c_rd), .BUSY(c_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within budget");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        z_r        = 1'b0;
        im_req     = 1'b0;
        dm_req     = 1'b0;
        dm_we      = 1'b0;
        im_addr    = '0;
        dm_addr    = '0;
        dm_wr_data = '0;
        repeat (3) tick();
        z_r = 1'b1;
        tick();
    endtask

    // Runs both requesters for 12 cycles and records the first three grants seen as ACKs.
    // With drop set, a requester releases REQ from its ACK until the following IDLE cycle has passed.
    task automatic collect(input bit use_b, input bit drop,
                           output int g0, output int g1, output int g2, output int ovl);
        int  n;
        int  im_off;
        int  dm_off;
        logic ia;
        logic da;
        g0 = 0; g1 = 0; g2 = 0; ovl = 0; n = 0; im_off = 0; dm_off = 0;
        im_addr = 32'h40;
        dm_addr = 32'h44;
        dm_we   = 1'b0;
        im_req  = 1'b1;
        dm_req  = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (im_off > 0) begin
                im_off--;
                if (im_off == 0) im_req = 1'b1;
            end
            if (dm_off > 0) begin
                dm_off--;
                if (dm_off == 0) dm_req = 1'b1;
            end
            ia = use_b ? b_im_ack : a_im_ack;
            da = use_b ? b_dm_ack : a_dm_ack;
            if (ia && da) ovl++;
            if (ia || da) begin
                if (n == 0) g0 = ia ? IM : DM;
                else if (n == 1) g1 = ia ? IM : DM;
                else if (n == 2) g2 = ia ? IM : DM;
                n++;
                if (drop) begin
                    if (ia) begin im_req = 1'b0; im_off = 2; end
                    else    begin dm_req = 1'b0; dm_off = 2; end
                end
            end
        end
        im_req = 1'b0;
        dm_req = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        z_r = 1'b0; im_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        im_addr = '0; dm_addr = '0; dm_wr_data = '0;
        repeat (3) tick();
        n_cmp++;
        if ({a_im_ack, a_dm_ack, a_im_data, a_dm_rd, a_en, a_we, a_addr, a_wd, a_busy} !== '0) begin
            n_err++;
            $display("FAIL reset_a: ack=%b%b imd=%h dmd=%h en=%b we=%b addr=%h wd=%h busy=%b, want all 0",
                     a_im_ack, a_dm_ack, a_im_data, a_dm_rd, a_en, a_we, a_addr, a_wd, a_busy);
        end
        n_cmp++;
        if ({b_im_ack, b_dm_ack, b_im_data, b_dm_rd, b_en, b_we, b_addr, b_wd, b_busy} !== '0) begin
            n_err++;
            $display("FAIL reset_b: outputs not all zero during reset");
        end
        n_cmp++;
        if ({c_im_ack, c_dm_ack, c_im_data, c_dm_rd, c_en, c_we, c_addr, c_wd, c_busy} !== '0) begin
            n_err++;
            $display("FAIL reset_c: outputs not all zero during reset");
        end
        z_r = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_cmp++;
            if ({a_en, b_en, c_en, a_busy, b_busy, c_busy, a_im_ack, a_dm_ack} !== 8'b0) begin
                n_err++;
                $display("FAIL idle_quiet[%0d]: en=%b%b%b busy=%b%b%b ack=%b%b, want 0",
                         k, a_en, b_en, c_en, a_busy, b_busy, c_busy, a_im_ack, a_dm_ack);
            end
        end
    endtask

    task automatic test_im_fetch();
        do_reset();
        im_req  = 1'b1;
        im_addr = 32'h0000_0010;
        tick();
        n_cmp++;
        if ({a_en, a_we, a_busy, a_im_ack, a_addr} !== {1'b1, 1'b0, 1'b1, 1'b0, 30'h4}) begin
            n_err++;
            $display("FAIL fetch_c1: en=%b we=%b busy=%b ack=%b addr=%h, want 1 0 1 0 4",
                     a_en, a_we, a_busy, a_im_ack, a_addr);
        end
        tick();
        n_cmp++;
        if ({a_en, a_we, a_im_ack} !== 3'b100) begin
            n_err++;
            $display("FAIL fetch_c2: en=%b we=%b ack=%b, want 1 0 0", a_en, a_we, a_im_ack);
        end
        tick();
        n_cmp++;
        if ({a_en, a_im_ack, a_dm_ack, a_im_data} !== {1'b0, 1'b1, 1'b0, 32'h8C01_0004}) begin
            n_err++;
            $display("FAIL fetch_ack: en=%b im_ack=%b dm_ack=%b data=%h, want 0 1 0 8c010004",
                     a_en, a_im_ack, a_dm_ack, a_im_data);
        end
        im_req = 1'b0;
        tick();
        n_cmp++;
        if ({a_im_ack, a_busy, a_en, a_im_data} !== {1'b0, 1'b0, 1'b0, 32'h8C01_0004}) begin
            n_err++;
            $display("FAIL fetch_after: ack=%b busy=%b en=%b data=%h, want 0 0 0 8c010004",
                     a_im_ack, a_busy, a_en, a_im_data);
        end
    endtask

    task automatic test_dm_write();
        do_reset();
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h24;
        repeat (3) tick();
        n_cmp++;
        if ({a_dm_ack, a_dm_rd} !== {1'b1, 32'h1234_5678}) begin
            n_err++;
            $display("FAIL dm_read: ack=%b data=%h, want 1 12345678", a_dm_ack, a_dm_rd);
        end
        dm_req = 1'b0;
        tick();
        dm_req     = 1'b1;
        dm_we      = 1'b1;
        dm_addr    = 32'h20;
        dm_wr_data = 32'hDEAD_BEEF;
        tick();
        n_cmp++;
        if ({a_en, a_we, a_addr, a_wd} !== {1'b1, 1'b0, 30'h8, 32'hDEAD_BEEF}) begin
            n_err++;
            $display("FAIL wr_c1: en=%b we=%b addr=%h wd=%h, want 1 0 8 deadbeef", a_en, a_we, a_addr, a_wd);
        end
        dm_addr    = 32'h3C;
        dm_wr_data = 32'h0;
        tick();
        n_cmp++;
        if ({a_en, a_we, a_addr, a_wd} !== {1'b1, 1'b1, 30'h8, 32'hDEAD_BEEF}) begin
            n_err++;
            $display("FAIL wr_c2: en=%b we=%b addr=%h wd=%h, want 1 1 8 deadbeef", a_en, a_we, a_addr, a_wd);
        end
        tick();
        n_cmp++;
        if ({a_en, a_we, a_dm_ack, a_im_ack, a_dm_rd} !== {1'b0, 1'b0, 1'b1, 1'b0, 32'h1234_5678}) begin
            n_err++;
            $display("FAIL wr_ack: en=%b we=%b dm_ack=%b im_ack=%b rd=%h, want 0 0 1 0 12345678",
                     a_en, a_we, a_dm_ack, a_im_ack, a_dm_rd);
        end
        dm_req = 1'b0;
        dm_we  = 1'b0;
        tick();
        n_cmp++;
        if ({a_we, a_dm_ack, a_busy} !== 3'b000) begin
            n_err++;
            $display("FAIL wr_after: we=%b ack=%b busy=%b, want 0 0 0", a_we, a_dm_ack, a_busy);
        end
    endtask

    task automatic test_arbitration();
        int g0, g1, g2, ovl;
        do_reset();
        collect(1'b0, 1'b1, g0, g1, g2, ovl);
        n_cmp++;
        if (g0 !== DM || g1 !== IM || g2 !== DM || ovl !== 0) begin
            n_err++;
            $display("FAIL prio_order: got %0d,%0d,%0d ovl=%0d, want %0d,%0d,%0d ovl=0", g0, g1, g2, ovl, DM, IM, DM);
        end
        do_reset();
        collect(1'b0, 1'b0, g0, g1, g2, ovl);
        n_cmp++;
        if (g0 !== DM || g1 !== DM || g2 !== DM || ovl !== 0) begin
            n_err++;
            $display("FAIL prio_starve: got %0d,%0d,%0d ovl=%0d, want %0d,%0d,%0d ovl=0", g0, g1, g2, ovl, DM, DM, DM);
        end
        do_reset();
        collect(1'b1, 1'b0, g0, g1, g2, ovl);
        n_cmp++;
        if (g0 !== IM || g1 !== DM || g2 !== IM || ovl !== 0) begin
            n_err++;
            $display("FAIL rr_order: got %0d,%0d,%0d ovl=%0d, want %0d,%0d,%0d ovl=0", g0, g1, g2, ovl, IM, DM, IM);
        end
    endtask

    task automatic test_reset_abort();
        do_reset();
        dm_req     = 1'b1;
        dm_we      = 1'b1;
        dm_addr    = 32'h20;
        dm_wr_data = 32'hCAFE_F00D;
        tick();
        z_r = 1'b0;
        #1;
        n_cmp++;
        if ({a_en, a_we, a_busy, a_dm_ack} !== 4'b0000) begin
            n_err++;
            $display("FAIL abort_drop: en=%b we=%b busy=%b ack=%b, want 0 0 0 0", a_en, a_we, a_busy, a_dm_ack);
        end
        @(negedge clk);
        z_r = 1'b1;
        tick();
        n_cmp++;
        if ({a_en, a_we, a_dm_ack, a_addr} !== {1'b1, 1'b0, 1'b0, 30'h8}) begin
            n_err++;
            $display("FAIL abort_r1: en=%b we=%b ack=%b addr=%h, want 1 0 0 8", a_en, a_we, a_dm_ack, a_addr);
        end
        tick();
        n_cmp++;
        if ({a_en, a_we, a_dm_ack, a_wd} !== {1'b1, 1'b1, 1'b0, 32'hCAFE_F00D}) begin
            n_err++;
            $display("FAIL abort_r2: en=%b we=%b ack=%b wd=%h, want 1 1 0 cafef00d", a_en, a_we, a_dm_ack, a_wd);
        end
        tick();
        n_cmp++;
        if ({a_en, a_we, a_dm_ack} !== 3'b001) begin
            n_err++;
            $display("FAIL abort_ack: en=%b we=%b ack=%b, want 0 0 1", a_en, a_we, a_dm_ack);
        end
        dm_req = 1'b0;
        dm_we  = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] want;
        do_reset();
        im_req  = 1'b1;
        im_addr = 32'h0;
        for (int j = 0; j < 3; j++) begin
            tick();
            n_cmp++;
            if ({c_en, c_we, c_busy, c_im_ack, c_addr} !== {1'b1, 1'b0, 1'b1, 1'b0, 30'(j)}) begin
                n_err++;
                $display("FAIL b2b_access[%0d]: en=%b we=%b busy=%b ack=%b addr=%h, want 1 0 1 0 %0d",
                         j, c_en, c_we, c_busy, c_im_ack, c_addr, j);
            end
            tick();
            want = rom[j];
            n_cmp++;
            if ({c_en, c_im_ack, c_busy, c_im_data} !== {1'b0, 1'b1, 1'b1, want}) begin
                n_err++;
                $display("FAIL b2b_ack[%0d]: en=%b ack=%b busy=%b data=%h, want 0 1 1 %h",
                         j, c_en, c_im_ack, c_busy, c_im_data, want);
            end
            im_addr = im_addr + 32'd4;
            if (j == 2) im_req = 1'b0;
            tick();
            n_cmp++;
            if ({c_busy, c_im_ack, c_en} !== 3'b000) begin
                n_err++;
                $display("FAIL b2b_gap[%0d]: busy=%b ack=%b en=%b, want 0 0 0", j, c_busy, c_im_ack, c_en);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 16; i++) rom[i] = 32'h1000_0000 + 32'(i);
        rom[0] = 32'h2001_0005;
        rom[1] = 32'h2002_0006;
        rom[2] = 32'h0022_1820;
        rom[4] = 32'h8C01_0004;
        rom[8] = 32'hA5A5_A5A5;
        rom[9] = 32'h1234_5678;

        test_reset();
        test_im_fetch();
        test_dm_write();
        test_arbitration();
        test_reset_abort();
        test_back_to_back();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
